sw_input_ctrl: RTL and testbench

SW_INPUT_CTRL -- requirements
Module: sw_input_ctrl

---
 rtl/sw_input_pkg.sv | 31 +++
 rtl/sw_debounce.sv | 88 ++++++++
 rtl/sw_input_ctrl.sv | 88 ++++++++
 tb/tb_sw_input_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sw_input_pkg.sv
// sw_input_pkg: shared types and register map for the switch input block.
// Build option: SW_DEBOUNCE_EN selects the debounce FSM in sw_debounce.
package sw_input_pkg;

    // Data word returned on the load path and carried by the switch bank
    typedef logic [31:0] sw_data_t;

    // Debounce FSM states
    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } sw_state_e;

    // Register offsets inside the 16-byte MMIO window (bits [1:0] ignored)
    localparam logic [3:0] OFS_SW   = 4'h0;
    localparam logic [3:0] OFS_CHG  = 4'h4;
    localparam logic [3:0] OFS_RSV0 = 4'h8;
    localparam logic [3:0] OFS_RSV1 = 4'hC;

    // Window hit test; the base is expected to be 16-byte aligned
    function automatic logic sw_in_window(input logic [31:0] addr,
                                          input logic [31:0] base);
        return (addr[31:4] == base[31:4]);
    endfunction

    // Word-aligned register offset of an address inside the window
    function automatic logic [3:0] sw_word_ofs(input logic [31:0] addr);
        return {addr[3:2], 2'b00};
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchronizer followed by a settle-count debouncer.
// Build option: SW_DEBOUNCE_EN compiles in the STABLE/SETTLING FSM; without it
// the synchronized value is forwarded directly and DEBOUNCE_CYCLES is unused.
module sw_debounce
    import sw_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  sw_data_t  i_io_sw,
    output sw_data_t  o_sw_stable,
    output logic      o_sw_changed
);

    // Parameter sanity: the settle counter is 16 bits wide
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_cfg_err
        $error("sw_debounce: DEBOUNCE_CYCLES out of range 2..65535");
    end

    sw_data_t r_sync1;
    sw_data_t r_sync2;
    sw_data_t r_sw_stable;
    logic     r_sw_changed;

    // Two-stage synchronizer for the asynchronous switch pins
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_io_sw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SW_DEBOUNCE_EN
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    sw_state_e   r_state;
    sw_data_t    r_cand;
    logic [15:0] r_cnt;

    // Debounce FSM: any difference restarts settling on the new candidate;
    // the candidate is published once it has held for DEBOUNCE_CYCLES edges.
    // Publishing an unchanged value is suppressed so no spurious pulse occurs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_STABLE;
            r_cand       <= '0;
            r_cnt        <= '0;
            r_sw_stable  <= '0;
            r_sw_changed <= 1'b0;
        end else begin
            r_sw_changed <= 1'b0;
            if (r_sync2 != r_cand) begin
                r_cand  <= r_sync2;
                r_cnt   <= '0;
                r_state <= ST_SETTLING;
            end else if (r_state == ST_SETTLING) begin
                r_cnt <= r_cnt + 16'd1;
                if (r_cnt == CNT_LAST) begin
                    r_state <= ST_STABLE;
                    if (r_cand != r_sw_stable) begin
                        r_sw_stable  <= r_cand;
                        r_sw_changed <= 1'b1;
                    end
                end
            end
        end
    end
`else
    // Pass-through: publish the synchronized value every cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sw_stable  <= '0;
            r_sw_changed <= 1'b0;
        end else begin
            r_sw_stable  <= r_sync2;
            r_sw_changed <= (r_sync2 != r_sw_stable);
        end
    end
`endif

    assign o_sw_stable  = r_sw_stable;
    assign o_sw_changed = r_sw_changed;

endmodule

// File: rtl/sw_input_ctrl.sv
// sw_input_ctrl: debounced switch bank exposed through a 16-byte load window.
//   +0x0 debounced switch value, +0x4 sticky change flag (clear on read),
//   +0x8/+0xC read as zero. Loads answer one cycle after the strobe.
// Build option: SW_DEBOUNCE_EN enables the debounce FSM inside sw_debounce.
module sw_input_ctrl
    import sw_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] SW_BASE_ADDR    = 32'h1001_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_io_sw,
    input  logic        i_lsu_rd,
    input  logic [31:0] i_lsu_addr,
    output logic [31:0] o_ld_data,
    output logic        o_ld_vld,
    output logic [31:0] o_sw_stable,
    output logic        o_sw_changed
);

    sw_data_t   w_sw_stable;
    logic       w_sw_changed;
    logic       w_hit;
    logic [3:0] w_ofs;
    logic       w_clr;
    sw_data_t   w_rd_data;
    logic       w_unused_addr_lo;

    logic       r_chg_flag;
    logic       r_ld_vld;
    sw_data_t   r_ld_data;

    sw_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_io_sw      (i_io_sw),
        .o_sw_stable  (w_sw_stable),
        .o_sw_changed (w_sw_changed)
    );

    // Byte-lane bits do not select a register
    assign w_unused_addr_lo = ^i_lsu_addr[1:0];

    assign w_hit = i_lsu_rd && sw_in_window(i_lsu_addr, SW_BASE_ADDR);
    assign w_ofs = sw_word_ofs(i_lsu_addr);
    assign w_clr = w_hit && (w_ofs == OFS_CHG);

    // Register read mux; the flag is returned as it was before this read clears it
    always_comb begin
        w_rd_data = '0;
        case (w_ofs)
            OFS_SW:  w_rd_data = w_sw_stable;
            OFS_CHG: w_rd_data = {31'b0, r_chg_flag};
            default: w_rd_data = '0;
        endcase
    end

    // Sticky change flag: a set arriving with a clear wins
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chg_flag <= 1'b0;
        end else if (w_sw_changed) begin
            r_chg_flag <= 1'b1;
        end else if (w_clr) begin
            r_chg_flag <= 1'b0;
        end
    end

    // Load response register: one-cycle latency, data forced to zero when idle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ld_vld  <= 1'b0;
            r_ld_data <= '0;
        end else begin
            r_ld_vld  <= w_hit;
            r_ld_data <= w_hit ? w_rd_data : '0;
        end
    end

    assign o_ld_vld     = r_ld_vld;
    assign o_ld_data    = r_ld_data;
    assign o_sw_stable  = w_sw_stable;
    assign o_sw_changed = w_sw_changed;

endmodule

// File: tb/tb_sw_input_ctrl.sv
// tb_sw_input_ctrl: directed scenarios plus randomized pins/loads/resets,
// every cycle compared against a run-length reference model.
module tb_sw_input_ctrl;

    localparam int          D    = 16;
    localparam logic [31:0] BASE = 32'h1001_0000;
`ifdef SW_DEBOUNCE_EN
    localparam int LAT           = D + 2;
    localparam int GLITCH_PULSES = 0;
`else
    localparam int LAT           = 2;
    localparam int GLITCH_PULSES = 2;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] pin;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] o_ld_data;
    logic        o_ld_vld;
    logic [31:0] o_sw_stable;
    logic        o_sw_changed;

    sw_input_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .SW_BASE_ADDR    (BASE)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_io_sw      (pin),
        .i_lsu_rd     (rd),
        .i_lsu_addr   (addr),
        .o_ld_data    (o_ld_data),
        .o_ld_vld     (o_ld_vld),
        .o_sw_stable  (o_sw_stable),
        .o_sw_changed (o_sw_changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pin history, run length of the synchronized value,
    // published value, sticky flag and load response
    logic [31:0] hist[$];
    logic [31:0] m_prev, m_stable, m_data;
    int          m_run;
    bit          m_chg, m_flag, m_vld;

    task automatic model_edge();
        logic [31:0] samp, rel;
        bit          nchg, hit;
        if (rst) begin
            hist = {32'h0, 32'h0};
            m_prev = 0; m_run = D + 1; m_stable = 0;
            m_chg = 0; m_flag = 0; m_vld = 0; m_data = 0;
            return;
        end
        // load response uses state from before this edge
        hit = rd && (addr >= BASE) && (addr <= BASE + 32'd15);
        rel = addr - BASE;
        m_vld = hit;
        m_data = 0;
        if (hit) begin
            case (rel / 4)
                0:       m_data = m_stable;
                1:       m_data = {31'b0, m_flag};
                default: m_data = 0;
            endcase
        end
        if (m_chg) m_flag = 1;
        else if (hit && (rel / 4 == 1)) m_flag = 0;
        // value seen by the debouncer is the pin from two edges back
        hist.push_back(pin);
        while (hist.size() > 3) void'(hist.pop_front());
        samp = hist[0];
        nchg = 0;
`ifdef SW_DEBOUNCE_EN
        if (samp != m_prev) m_run = 1;
        else if (m_run < D + 1) m_run++;
        m_prev = samp;
        if (m_run == D + 1 && samp != m_stable) begin
            m_stable = samp;
            nchg = 1;
        end
`else
        nchg = (samp != m_stable);
        m_stable = samp;
`endif
        m_chg = nchg;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("stable",  o_sw_stable,  m_stable);
        chk("changed", o_sw_changed, m_chg);
        chk("ld_vld",  o_ld_vld,     m_vld);
        chk("ld_data", o_ld_data,    m_data);
    endtask

    task automatic load(input logic [31:0] a);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    int n, pulses, hold;
    logic [31:0] pool[5];

    initial begin
        rst = 1'b1; pin = 0; rd = 0; addr = 0;
        repeat (3) tick();
        chk("rst_stable0", o_sw_stable, 32'h0);
        chk("rst_vld0",    o_ld_vld,    32'h0);
        rst = 1'b0;
        repeat (2) tick();

        // steady A5: latency from first capture, single pulse
        pin = 32'h0000_00A5;
        tick();
        n = 0; pulses = 0;
        while (o_sw_stable !== 32'hA5 && n < 200) begin
            tick(); n++;
            if (o_sw_changed) pulses++;
        end
        chk("latency", n, LAT);
        repeat (20) begin tick(); if (o_sw_changed) pulses++; end
        chk("a5_pulses", pulses, 1);

        // back-to-back reads, then a re-read of the cleared flag
        addr = BASE; rd = 1;
        tick();
        chk("rd_sw_vld", o_ld_vld, 1);
        chk("rd_sw", o_ld_data, 32'hA5);
        addr = BASE + 4;
        tick();
        chk("rd_chg_vld", o_ld_vld, 1);
        chk("rd_chg", o_ld_data, 1);
        rd = 0;
        tick();
        chk("idle_data", o_ld_data, 0);
        load(BASE + 4);
        chk("rd_chg2", o_ld_data, 0);
        load(BASE + 32'h20);
        chk("rd_out_vld", o_ld_vld, 0);
        load(BASE + 8);
        chk("rd_rsv_vld", o_ld_vld, 1);
        chk("rd_rsv", o_ld_data, 0);
        load(BASE + 3);
        chk("rd_lowbits", o_ld_data, 32'hA5);

        // short glitch on bit 3
        pulses = 0;
        pin = 32'hAD;
        repeat (10) begin tick(); if (o_sw_changed) pulses++; end
        pin = 32'hA5;
        repeat (40) begin tick(); if (o_sw_changed) pulses++; end
        chk("glitch_pulses", pulses, GLITCH_PULSES);
        chk("glitch_stable", o_sw_stable, 32'hA5);

        // reset in the middle of settling, with a coincident load
        pin = 32'h3C;
        repeat (10) tick();
        rst = 1; addr = BASE; rd = 1;
        tick();
        chk("mid_rst_stable", o_sw_stable, 0);
        chk("mid_rst_changed", o_sw_changed, 0);
        rst = 0; rd = 0;
        tick();
        chk("rst_load_drop", o_ld_vld, 0);

        // randomized traffic
        pool[0] = 32'h0; pool[1] = 32'hA5; pool[2] = 32'h5A;
        pool[3] = 32'hFFFF_FFFF; pool[4] = 32'h0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                pool[4] = $urandom;
                pin  = pool[$urandom_range(0, 4)];
                hold = $urandom_range(1, 24);
            end
            hold--;
            rd = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0, 1:    addr = BASE + 32'($urandom_range(0, 15));
                2:       addr = BASE + 32'd4 + 32'($urandom_range(0, 3));
                3:       addr = ($urandom_range(0, 1) == 0) ? BASE - 32'd1 : BASE + 32'd16;
                default: addr = $urandom;
            endcase
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0; rd = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
